// File: rtl/qspi_multi_lock_arb.sv
// ---------------------------------------------------------------------------
// qspi_multi_lock_arb
//
// Purpose:
//   Round-robin lock arbiter that grants one of NCH instruction channels
//   exclusive ownership of the shared QSPI write-data path. An owner keeps
//   the lock until it pulses its key, its declared beat count runs out, or
//   the data path stays idle for 2^TO_W-1 cycles. One GAP cycle always
//   separates two owners, so multi-word write data never interleaves.
//
// Ports:
//   clock          in   system clock
//   rst_n          in   asynchronous active-low reset
//   io_lock_req    in   [NCH]        per-channel lock request (level)
//   io_lock_len    in   [NCH*CNT_W]  per-channel beat count, 0 = unbounded
//   io_key         in   [NCH]        per-channel release pulse
//   io_beat        in   one data word accepted by the shared path
//   io_tdata_lock  out  data path locked (includes same-cycle new grant)
//   io_owner       out  [NCH]   one-hot current owner
//   io_owner_id    out  [ID_W]  binary current owner (valid when owner!=0)
//   io_chan_block  out  [NCH]   channel must not push data
//   io_remain      out  [CNT_W] beats left for the current owner
//   io_timeout     out  one-cycle pulse after an idle-timeout release
// ---------------------------------------------------------------------------
module qspi_multi_lock_arb #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8,
    parameter int TO_W  = 12,
    parameter int ID_W  = 2
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       io_lock_req,
    input  logic [NCH*CNT_W-1:0] io_lock_len,
    input  logic [NCH-1:0]       io_key,
    input  logic                 io_beat,
    output logic                 io_tdata_lock,
    output logic [NCH-1:0]       io_owner,
    output logic [ID_W-1:0]      io_owner_id,
    output logic [NCH-1:0]       io_chan_block,
    output logic [CNT_W-1:0]     io_remain,
    output logic                 io_timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t           r_state;
    logic [NCH-1:0]   r_owner;
    logic [ID_W-1:0]  r_ownerId;
    logic [ID_W-1:0]  r_ptr;
    logic [CNT_W-1:0] r_remain;
    logic [TO_W-1:0]  r_idle;
    logic             r_timeout;

    logic [NCH-1:0]   w_req;
    logic             w_found;
    logic [ID_W-1:0]  w_pickId;
    logic [NCH-1:0]   w_pick;
    logic [CNT_W-1:0] w_pickLen;
    logic             w_keyRel;
    logic             w_cntRel;
    logic             w_toRel;
    logic             w_release;

    // A key in the same cycle as a request cancels that request.
    assign w_req = io_lock_req & ~io_key;

    // Round-robin pick: first requester strictly after the last owner.
    always_comb begin
        int idx;
        w_found  = 1'b0;
        w_pickId = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(r_ptr) + k) % NCH;
            if (!w_found && w_req[idx]) begin
                w_found  = 1'b1;
                w_pickId = ID_W'(idx);
            end
        end
    end

    always_comb begin
        w_pick    = '0;
        w_pickLen = io_lock_len[int'(w_pickId)*CNT_W +: CNT_W];
        if (w_found && r_state == IDLE) begin
            w_pick = NCH'(1) << w_pickId;
        end
    end

    // Release sources while LOCKED; they share one release path.
    // A bounded lock always releases at remain==1, so remain==0 in LOCKED
    // means unbounded.
    assign w_keyRel  = io_key[r_ownerId];
    assign w_cntRel  = io_beat && (r_remain == CNT_W'(1));
    assign w_toRel   = !io_beat && (r_idle == {TO_W{1'b1}});
    assign w_release = w_keyRel || w_cntRel || w_toRel;

    // Lock covers the grant cycle combinationally so the winner is
    // protected with zero latency; GAP blocks everybody.
    assign io_tdata_lock = (r_state != IDLE) || (w_req != '0);
    assign io_chan_block = io_tdata_lock ? ~(r_owner | w_pick) : '0;
    assign io_owner      = r_owner;
    assign io_owner_id   = r_ownerId;
    assign io_remain     = r_remain;
    assign io_timeout    = r_timeout;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_owner   <= '0;
            r_ownerId <= '0;
            r_ptr     <= ID_W'(NCH-1);
            r_remain  <= '0;
            r_idle    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state   <= LOCKED;
                        r_owner   <= NCH'(1) << w_pickId;
                        r_ownerId <= w_pickId;
                        r_ptr     <= w_pickId;
                        r_remain  <= w_pickLen;
                        r_idle    <= '0;
                    end
                end
                LOCKED: begin
                    if (w_release) begin
                        r_state   <= GAP;
                        r_owner   <= '0;
                        r_ownerId <= '0;
                        r_remain  <= '0;
                        r_idle    <= '0;
                        r_timeout <= w_toRel;
                    end else if (io_beat) begin
                        r_idle <= '0;
                        if (r_remain != '0) begin
                            r_remain <= r_remain - CNT_W'(1);
                        end
                    end else begin
                        r_idle <= r_idle + TO_W'(1);
                    end
                end
                GAP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_multi_lock_arb.sv
// ---------------------------------------------------------------------------
// tb_qspi_multi_lock_arb
//
// Scoreboard bench: every driven cycle pushes the reference model's expected
// outputs into a queue; an independent monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_qspi_multi_lock_arb;

    localparam int NCH     = 4;
    localparam int CNT_W   = 8;
    localparam int TO_W    = 12;
    localparam int ID_W    = 2;
    localparam int MAXIDLE = (1 << TO_W) - 1;

    logic                 clock;
    logic                 rst_n;
    logic [NCH-1:0]       io_lock_req;
    logic [NCH*CNT_W-1:0] io_lock_len;
    logic [NCH-1:0]       io_key;
    logic                 io_beat;
    logic                 io_tdata_lock;
    logic [NCH-1:0]       io_owner;
    logic [ID_W-1:0]      io_owner_id;
    logic [NCH-1:0]       io_chan_block;
    logic [CNT_W-1:0]     io_remain;
    logic                 io_timeout;

    qspi_multi_lock_arb #(
        .NCH(NCH), .CNT_W(CNT_W), .TO_W(TO_W), .ID_W(ID_W)
    ) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .io_lock_req   (io_lock_req),
        .io_lock_len   (io_lock_len),
        .io_key        (io_key),
        .io_beat       (io_beat),
        .io_tdata_lock (io_tdata_lock),
        .io_owner      (io_owner),
        .io_owner_id   (io_owner_id),
        .io_chan_block (io_chan_block),
        .io_remain     (io_remain),
        .io_timeout    (io_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic             lock;
        logic [NCH-1:0]   owner;
        logic [ID_W-1:0]  id;
        logic [NCH-1:0]   block;
        logic [CNT_W-1:0] remain;
        logic             tout;
    } exp_t;

    exp_t expQ[$];

    int checks = 0;
    int errors = 0;
    int toSeen = 0;

    // Reference model: who owns the path, whether a gap is pending, and the
    // owner's remaining beats / idle streak.
    int mOwner;
    int mLast;
    int mRem;
    int mIdle;
    bit mGap;
    bit mTo;
    int lenArr[NCH];

    task automatic modelReset();
        mOwner = -1;
        mLast  = NCH - 1;
        mRem   = 0;
        mIdle  = 0;
        mGap   = 1'b0;
        mTo    = 1'b0;
    endtask

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkVal("tdata_lock", int'(io_tdata_lock), int'(e.lock));
        checkVal("owner", int'(io_owner), int'(e.owner));
        if (e.owner != '0) checkVal("owner_id", int'(io_owner_id), int'(e.id));
        checkVal("chan_block", int'(io_chan_block), int'(e.block));
        checkVal("remain", int'(io_remain), int'(e.remain));
        checkVal("timeout", int'(io_timeout), int'(e.tout));
    endtask

    // One cycle of stimulus: drive inputs, predict outputs, advance model.
    task automatic applyStimulus(input logic [NCH-1:0] req, input logic [NCH-1:0] key,
                                 input logic beat);
        exp_t e;
        logic [NCH-1:0] elig;
        int win;
        @(negedge clock);
        io_lock_req = req;
        io_key      = key;
        io_beat     = beat;
        for (int i = 0; i < NCH; i++) io_lock_len[i*CNT_W +: CNT_W] = CNT_W'(lenArr[i]);

        elig = req & ~key;
        win  = -1;
        for (int k = 1; k <= NCH; k++) begin
            if (win < 0 && elig[(mLast + k) % NCH]) win = (mLast + k) % NCH;
        end

        e.tout = mTo;
        e.id   = '0;
        if (mOwner >= 0) begin
            e.lock   = 1'b1;
            e.owner  = NCH'(1) << mOwner;
            e.id     = ID_W'(mOwner);
            e.block  = ~e.owner;
            e.remain = CNT_W'(mRem);
        end else if (mGap) begin
            e.lock   = 1'b1;
            e.owner  = '0;
            e.block  = '1;
            e.remain = '0;
        end else begin
            e.lock   = (win >= 0);
            e.owner  = '0;
            e.block  = (win >= 0) ? ~(NCH'(1) << win) : '0;
            e.remain = '0;
        end
        expQ.push_back(e);

        mTo = 1'b0;
        if (mOwner >= 0) begin
            bit keyRel, cntRel, toRel;
            keyRel = key[mOwner];
            cntRel = beat && (mRem == 1);
            toRel  = !beat && (mIdle == MAXIDLE);
            if (keyRel || cntRel || toRel) begin
                mOwner = -1;
                mGap   = 1'b1;
                mTo    = toRel;
                mRem   = 0;
            end else if (beat) begin
                mIdle = 0;
                if (mRem > 0) mRem--;
            end else begin
                mIdle++;
            end
        end else if (mGap) begin
            mGap = 1'b0;
        end else if (win >= 0) begin
            mOwner = win;
            mLast  = win;
            mRem   = lenArr[win];
            mIdle  = 0;
        end
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic doReset();
        @(negedge clock);
        io_lock_req = '0;
        io_key      = '0;
        io_beat     = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        checkVal("rst_lock", int'(io_tdata_lock), 0);
        checkVal("rst_owner", int'(io_owner), 0);
        checkVal("rst_owner_id", int'(io_owner_id), 0);
        checkVal("rst_block", int'(io_chan_block), 0);
        checkVal("rst_remain", int'(io_remain), 0);
        checkVal("rst_timeout", int'(io_timeout), 0);
        @(negedge clock);
        rst_n = 1'b1;
        modelReset();
    endtask

    // Monitor: compares whatever the scoreboard expects for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    always @(negedge clock) begin
        if (rst_n && io_timeout) toSeen++;
    end

    initial begin
        int toBase;
        rst_n       = 1'b0;
        io_lock_req = '0;
        io_key      = '0;
        io_beat     = 1'b0;
        io_lock_len = '0;
        for (int i = 0; i < NCH; i++) lenArr[i] = 0;
        modelReset();
        #3;
        checkVal("init_lock", int'(io_tdata_lock), 0);
        checkVal("init_owner", int'(io_owner), 0);
        @(negedge clock);
        rst_n = 1'b1;

        // Bounded lock of 3 beats on channel 0.
        $display("[TB] bounded lock");
        lenArr[0] = 3;
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        repeat (3) applyStimulus(4'b0000, 4'b0000, 1'b1);
        repeat (3) applyStimulus(4'b0000, 4'b0000, 1'b0);

        // All channels requesting, one-beat locks rotate.
        $display("[TB] round robin");
        for (int i = 0; i < NCH; i++) lenArr[i] = 1;
        repeat (16) applyStimulus(4'b1111, 4'b0000, 1'b1);
        repeat (2) applyStimulus(4'b0000, 4'b0000, 1'b0);

        // Unbounded lock on channel 2, foreign key ignored, own key releases.
        $display("[TB] unbounded lock and keys");
        lenArr[2] = 0;
        applyStimulus(4'b0100, 4'b0000, 1'b0);
        repeat (10) applyStimulus(4'b0000, 4'b0000, 1'b1);
        applyStimulus(4'b0000, 4'b0010, 1'b0);
        repeat (2) applyStimulus(4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 4'b0100, 1'b0);
        repeat (3) applyStimulus(4'b0000, 4'b0000, 1'b0);

        // Idle timeout on channel 1, then a late beat that restarts the count.
        $display("[TB] idle timeout");
        toBase = toSeen;
        lenArr[1] = 5;
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        repeat (MAXIDLE + 4) applyStimulus(4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        repeat (4000) applyStimulus(4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        repeat (200) applyStimulus(4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 4'b0010, 1'b0);
        repeat (3) applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkVal("timeout_pulses", toSeen - toBase, 1);

        // Key in the same cycle as a request masks it.
        $display("[TB] key masks request");
        lenArr[3] = 2;
        applyStimulus(4'b1000, 4'b1000, 1'b0);
        applyStimulus(4'b1000, 4'b0000, 1'b0);
        repeat (2) applyStimulus(4'b0000, 4'b0000, 1'b1);
        repeat (2) applyStimulus(4'b0000, 4'b0000, 1'b0);

        // Reset in the middle of a bounded transfer, then fresh arbitration.
        $display("[TB] reset mid-lock");
        lenArr[0] = 5;
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        repeat (2) applyStimulus(4'b0000, 4'b0000, 1'b1);
        doReset();
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 4'b0010, 1'b0);
        repeat (2) applyStimulus(4'b0000, 4'b0000, 1'b0);

        // Randomised traffic.
        $display("[TB] random traffic");
        for (int n = 0; n < 2000; n++) begin
            logic [NCH-1:0] rq, ky;
            for (int i = 0; i < NCH; i++) lenArr[i] = $urandom_range(0, 4);
            rq = NCH'($urandom);
            ky = '0;
            for (int i = 0; i < NCH; i++) ky[i] = ($urandom_range(0, 7) == 0);
            applyStimulus(rq, ky, 1'($urandom_range(0, 1)));
        end
        applyStimulus(4'b0000, 4'b0000, 1'b0);

        // Let the monitor drain the scoreboard, bounded.
        for (int w = 0; w < 10 && expQ.size() > 0; w++) @(negedge clock);
        #5;
        if (expQ.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
